// File: rtl/vec_accumulator.sv
// Multi-lane beat accumulator: sums LANES partial-sum lanes over a
// programmable group length and emits one width-converted result per group.
module vec_accumulator #(
  parameter int W_IN      = 18,
  parameter int LANES     = 4,
  parameter int MAX_BEATS = 16,
  parameter int W_OUT     = 22,
  parameter int SIGNED    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(MAX_BEATS):0] cfg_beats,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*W_IN-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*W_OUT-1:0]   out_data,
  output logic [LANES-1:0]         out_sat,
  output logic                     busy
);

  localparam int CW    = $clog2(MAX_BEATS) + 1;
  localparam int W_ACC = W_IN + $clog2(MAX_BEATS);

  logic [CW-1:0] count_q;
  logic [CW-1:0] beats_q;
  logic [CW-1:0] cfg_eff;
  logic [CW-1:0] beats_eff;

  logic [LANES-1:0][W_ACC-1:0] sum_q;
  logic [LANES-1:0][W_ACC-1:0] tot;
  logic [LANES-1:0][W_OUT-1:0] conv;
  logic [LANES-1:0]            sat;

  logic is_last;
  logic take;
  logic take_last;
  logic take_mid;

  always_comb begin
    unique case (1'b1)
      cfg_beats == '0:             cfg_eff = CW'(1);
      cfg_beats > CW'(MAX_BEATS):  cfg_eff = CW'(MAX_BEATS);
      default:                     cfg_eff = cfg_beats;
    endcase
  end

  // The first beat of a group decides its length from the live config.
  assign beats_eff = (count_q == '0) ? cfg_eff : beats_q;
  assign is_last   = (count_q == beats_eff - CW'(1));

  assign in_ready  = !clear && !(is_last && out_valid && !out_ready);
  assign take      = in_valid && in_ready;
  assign take_last = take && is_last;
  assign take_mid  = take && !is_last;
  assign busy      = (count_q != '0);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [W_IN-1:0]  lane_in;
    logic [W_ACC-1:0] lane_ext;
    logic [W_ACC-1:0] lane_tot;
    logic [W_OUT-1:0] lane_cv;
    logic             lane_sat;

    assign lane_in  = in_data[g*W_IN +: W_IN];
    assign lane_ext = {{(W_ACC-W_IN){(SIGNED != 0) && lane_in[W_IN-1]}},
                       lane_in};
    assign lane_tot = sum_q[g] + lane_ext;

    if (W_OUT >= W_ACC) begin : g_wide
      always_comb begin
        lane_cv = {W_OUT{(SIGNED != 0) && lane_tot[W_ACC-1]}};
        lane_cv[W_ACC-1:0] = lane_tot;
      end
      assign lane_sat = 1'b0;
    end else if (SIGNED != 0) begin : g_sclamp
      // In range only when every bit above the output sign bit matches it.
      logic [W_ACC-W_OUT:0] hi;
      assign hi       = lane_tot[W_ACC-1:W_OUT-1];
      assign lane_sat = !((&hi) || !(|hi));
      assign lane_cv  = !lane_sat ? lane_tot[W_OUT-1:0] :
                        lane_tot[W_ACC-1] ? {1'b1, {(W_OUT-1){1'b0}}} :
                                            {1'b0, {(W_OUT-1){1'b1}}};
    end else begin : g_uclamp
      assign lane_sat = |lane_tot[W_ACC-1:W_OUT];
      assign lane_cv  = lane_sat ? {W_OUT{1'b1}} : lane_tot[W_OUT-1:0];
    end

    assign tot[g]  = lane_tot;
    assign conv[g] = lane_cv;
    assign sat[g]  = lane_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      beats_q   <= '0;
      sum_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else begin
      unique case (1'b1)
        clear: begin
          count_q <= '0;
          sum_q   <= '0;
        end
        take_last: begin
          count_q  <= '0;
          sum_q    <= '0;
          out_data <= conv;
          out_sat  <= sat;
        end
        take_mid: begin
          count_q <= count_q + CW'(1);
          sum_q   <= tot;
        end
        default: ;
      endcase
      if (take && count_q == '0)
        beats_q <= cfg_eff;
      out_valid <= take_last || (out_valid && !out_ready);
    end
  end

endmodule

// File: tb/tb_vec_accumulator.sv
// Self-checking bench for vec_accumulator: three configurations share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_vec_accumulator;

  localparam int W_IN  = 18;
  localparam int LANES = 4;
  localparam int CW    = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic in_valid;
  logic out_ready;
  logic [CW-1:0] cfg_beats;
  logic [LANES*W_IN-1:0] in_data;

  logic r0, r1, r2;
  logic v0, v1, v2;
  logic b0, b1, b2;
  logic [87:0] d0;
  logic [79:0] d1, d2;
  logic [3:0] s0, s1, s2;

  int n_tot = 0;
  int n_bad = 0;
  bit bias = 0;

  always #5 clk = ~clk;

  vec_accumulator #(.W_OUT(22), .SIGNED(1)) u0 (
    .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .clear(clear),
    .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
    .out_valid(v0), .out_ready(out_ready), .out_data(d0),
    .out_sat(s0), .busy(b0)
  );

  vec_accumulator #(.W_OUT(20), .SIGNED(1)) u1 (
    .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .clear(clear),
    .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
    .out_valid(v1), .out_ready(out_ready), .out_data(d1),
    .out_sat(s1), .busy(b1)
  );

  vec_accumulator #(.W_OUT(20), .SIGNED(0)) u2 (
    .clk(clk), .rst_n(rst_n), .cfg_beats(cfg_beats), .clear(clear),
    .in_valid(in_valid), .in_ready(r2), .in_data(in_data),
    .out_valid(v2), .out_ready(out_ready), .out_data(d2),
    .out_sat(s2), .busy(b2)
  );

  task automatic chk(input string nm, input logic [127:0] a,
                     input logic [127:0] e);
    n_tot++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic longint lane_s(input logic [71:0] d, input int i);
    logic signed [17:0] x;
    x = d[i*18 +: 18];
    return longint'(x);
  endfunction

  function automatic longint lane_u(input logic [71:0] d, input int i);
    logic [17:0] x;
    x = d[i*18 +: 18];
    return longint'(x);
  endfunction

  function automatic logic [71:0] dpk(input longint a, input longint b,
                                      input longint c, input longint d);
    longint l[4];
    logic [71:0] r;
    l = '{a, b, c, d};
    r = '0;
    for (int i = 0; i < 4; i++)
      r[i*18 +: 18] = l[i][17:0];
    return r;
  endfunction

  function automatic logic [127:0] pkv(input int w, input longint a,
                                       input longint b, input longint c,
                                       input longint d);
    longint l[4];
    logic [127:0] v, msk;
    l = '{a, b, c, d};
    v = '0;
    msk = (128'(1) << w) - 128'(1);
    for (int i = 0; i < 4; i++)
      v = v | ((128'(l[i]) & msk) << (i*w));
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  int     m_cnt, m_beats;
  bit     m_ov;
  longint ms[4], mu[4], rs[4], ru[4];

  function automatic int clampc(input int c);
    if (c == 0) return 1;
    if (c > 16) return 16;
    return c;
  endfunction

  function automatic int eff_beats();
    return (m_cnt == 0) ? clampc(int'(cfg_beats)) : m_beats;
  endfunction

  function automatic bit exp_rdy();
    bit last;
    last = (m_cnt == eff_beats() - 1);
    return !clear && !(last && m_ov && !out_ready);
  endfunction

  task automatic model_reset();
    m_cnt = 0;
    m_beats = 0;
    m_ov = 0;
    for (int i = 0; i < 4; i++) begin
      ms[i] = 0; mu[i] = 0; rs[i] = 0; ru[i] = 0;
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit take, last, load;
      last = (m_cnt == eff_beats() - 1);
      take = in_valid && exp_rdy();
      load = 0;
      if (clear) begin
        m_cnt = 0;
        for (int i = 0; i < 4; i++) begin
          ms[i] = 0; mu[i] = 0;
        end
      end else if (take) begin
        if (m_cnt == 0) m_beats = clampc(int'(cfg_beats));
        for (int i = 0; i < 4; i++) begin
          if (last) begin
            rs[i] = ms[i] + lane_s(in_data, i);
            ru[i] = mu[i] + lane_u(in_data, i);
            ms[i] = 0; mu[i] = 0;
          end else begin
            ms[i] += lane_s(in_data, i);
            mu[i] += lane_u(in_data, i);
          end
        end
        if (last) begin
          m_cnt = 0;
          load = 1;
        end else begin
          m_cnt++;
        end
      end
      m_ov = load || (m_ov && !out_ready);
    end
  end

  task automatic build(input bit sg, input int w,
                       output logic [127:0] e, output logic [3:0] es);
    logic [127:0] msk;
    longint v, mx, mn;
    msk = (128'(1) << w) - 128'(1);
    e = '0;
    es = '0;
    if (sg) begin
      mx = (64'sd1 <<< (w-1)) - 1;
      mn = -(64'sd1 <<< (w-1));
    end else begin
      mx = (64'sd1 <<< w) - 1;
      mn = 0;
    end
    for (int i = 0; i < 4; i++) begin
      v = sg ? rs[i] : ru[i];
      if (v > mx) begin v = mx; es[i] = 1'b1; end
      else if (v < mn) begin v = mn; es[i] = 1'b1; end
      e = e | ((128'(v) & msk) << (i*w));
    end
  endtask

  always @(negedge clk) begin
    logic [127:0] e;
    logic [3:0] es;
    bit er;
    er = exp_rdy();
    chk("rdy0", r0, er);
    chk("rdy1", r1, er);
    chk("rdy2", r2, er);
    chk("valid0", v0, m_ov);
    chk("valid1", v1, m_ov);
    chk("valid2", v2, m_ov);
    chk("busy0", b0, m_cnt != 0);
    chk("busy2", b2, m_cnt != 0);
    build(1, 22, e, es);
    chk("data0", d0, e);
    chk("sat0", s0, es);
    build(1, 20, e, es);
    chk("data1", d1, e);
    chk("sat1", s1, es);
    build(0, 20, e, es);
    chk("data2", d2, e);
    chk("sat2", s2, es);
  end

  // ---------------- stimulus ----------------
  function automatic logic [71:0] rnd();
    logic [71:0] r;
    for (int i = 0; i < 4; i++) begin
      int p;
      p = $urandom_range(0, 7);
      if (bias && p < 6) r[i*18 +: 18] = 18'h1FFFF;
      else if (p == 0)   r[i*18 +: 18] = 18'h1FFFF;
      else if (p == 1)   r[i*18 +: 18] = 18'h20000;
      else if (p == 2)   r[i*18 +: 18] = 18'h3FFFF;
      else               r[i*18 +: 18] = 18'($urandom);
    end
    return r;
  endfunction

  task automatic send(input logic [71:0] d);
    bit ok;
    ok = 0;
    in_data = d;
    in_valid = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ok = r0;
      @(posedge clk);
      #2;
      if (ok) break;
    end
    if (!ok) begin
      n_tot++;
      n_bad++;
      $display("FAIL send_timeout: got no in_ready want accept");
    end
    in_valid = 0;
  endtask

  task automatic drain();
    out_ready = 1;
    @(posedge clk);
    #2;
    out_ready = 0;
  endtask

  initial begin
    logic [71:0] prev;
    rst_n = 1; clear = 0; in_valid = 0; out_ready = 0;
    cfg_beats = 2; in_data = '0;
    #1 rst_n = 0;
    #1;
    chk("rst_valid", v0, 0);
    chk("rst_busy", b0, 0);
    chk("rst_data", d0, 0);
    chk("rst_sat", s1, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;

    // basic two-beat group
    cfg_beats = 2;
    send(dpk(5, -3, 100, 0));
    send(dpk(7, 3, -200, 1));
    chk("t1_valid", v0, 1);
    chk("t1_data", d0, pkv(22, 12, 0, -100, 1));
    chk("t1_data20", d1, pkv(20, 12, 0, -100, 1));
    chk("t1_sat", s0, 0);
    drain();
    chk("t1_drained", v0, 0);

    // full-scale groups across the three output widths
    cfg_beats = 16;
    repeat (16) send(dpk(-131072, -131072, -131072, -131072));
    chk("t2_d22", d0, pkv(22, -2097152, -2097152, -2097152, -2097152));
    chk("t2_s22", s0, 0);
    chk("t2_d20", d1, pkv(20, -524288, -524288, -524288, -524288));
    chk("t2_s20", s1, 4'hF);
    chk("t2_du", d2, pkv(20, 1048575, 1048575, 1048575, 1048575));
    drain();
    repeat (16) send(dpk(262143, 262143, 262143, 262143));
    chk("t2b_du", d2, pkv(20, 1048575, 1048575, 1048575, 1048575));
    chk("t2b_su", s2, 4'hF);
    chk("t2b_d22", d0, pkv(22, -16, -16, -16, -16));
    drain();

    // single-beat streaming
    cfg_beats = 1;
    out_ready = 1;
    in_valid = 1;
    prev = '0;
    for (int k = 0; k < 20; k++) begin
      in_data = rnd();
      @(negedge clk);
      chk("t3_rdy", r0, 1);
      if (k > 0) begin
        chk("t3_valid", v0, 1);
        chk("t3_data", d0, pkv(22, lane_s(prev, 0), lane_s(prev, 1),
                               lane_s(prev, 2), lane_s(prev, 3)));
      end
      prev = in_data;
      @(posedge clk);
      #2;
    end
    in_valid = 0;
    @(posedge clk);
    #2 out_ready = 0;

    // output stall blocks only the last beat
    cfg_beats = 4;
    repeat (4) send(dpk(1, 2, 3, 4));
    repeat (3) send(dpk(10, -10, 0, 5));
    chk("t4_busy", b0, 1);
    in_data = dpk(10, -10, 0, 5);
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_stall", r0, 0);
      chk("t4_hold", d0, pkv(22, 4, 8, 12, 16));
      @(posedge clk);
    end
    #2 out_ready = 1;
    @(negedge clk);
    chk("t4_rdy", r0, 1);
    @(posedge clk);
    #2;
    in_valid = 0;
    out_ready = 0;
    chk("t4_valid", v0, 1);
    chk("t4_data", d0, pkv(22, 40, -40, 0, 20));
    drain();

    // clear drops the group and the coincident beat
    cfg_beats = 3;
    send(dpk(100, 100, 100, 100));
    send(dpk(100, 100, 100, 100));
    clear = 1;
    in_data = dpk(999, 999, 999, 999);
    in_valid = 1;
    @(posedge clk);
    #2;
    clear = 0;
    in_valid = 0;
    chk("t5_busy", b0, 0);
    chk("t5_noout", v0, 0);
    send(dpk(1, 2, 3, 4));
    cfg_beats = 8;
    send(dpk(1, 1, 1, 1));
    send(dpk(-1, 0, 0, 2));
    chk("t5_valid", v0, 1);
    chk("t5_data", d0, pkv(22, 1, 3, 4, 7));
    drain();
    repeat (7) send(dpk(1, 1, 1, 1));
    chk("t5_len8", v0, 0);
    send(dpk(1, 1, 1, 1));
    chk("t5_data8", d0, pkv(22, 8, 8, 8, 8));
    drain();

    // reset mid-group with a pending result
    cfg_beats = 4;
    repeat (4) send(dpk(1, 1, 1, 1));
    repeat (2) send(dpk(2, 2, 2, 2));
    rst_n = 0;
    #1;
    chk("t6_valid", v0, 0);
    chk("t6_data", d0, 0);
    chk("t6_busy", b0, 0);
    #1 rst_n = 1;
    @(posedge clk);
    #2 cfg_beats = 0;
    send(dpk(3, 4, 5, 6));
    chk("t6_cfg0", v0, 1);
    chk("t6_sum", d0, pkv(22, 3, 4, 5, 6));
    drain();

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      bias = ((k / 300) % 2) == 1;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 49) == 0);
      cfg_beats = CW'($urandom_range(0, 31));
      in_data = rnd();
      @(posedge clk);
      #2;
    end
    in_valid = 0;
    clear = 0;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/vec_accumulator.md
Name: vec_accumulator

Overview:
Multi-lane, runtime-configurable successor to the single-lane 2-beat accumulator. It sums LANES parallel partial-sum lanes over a programmable number of beats (1..MAX_BEATS). Inputs can be signed or unsigned, and the output is extended or saturated to W_OUT. It sits between the MAC array's partial-sum output and the result writeback, and uses a valid/ready handshake on both sides.

Parameters:
- W_IN, 18: width of each lane's partial sum.
- LANES, 4: number of parallel lanes.
- MAX_BEATS, 16: maximum beats per group (power of two, at least 2).
- W_OUT, 22: width of each output lane.
- SIGNED, 1: 1 means inputs are two's complement; 0 means unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_beats  in  $clog2(MAX_BEATS)+1  beats per group; sampled on the first beat of each group.
- clear  in  1  synchronous flush of the group in progress.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_data  in  LANES*W_IN  lane i occupies bits [i*W_IN +: W_IN].
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  LANES*W_OUT  lane i occupies bits [i*W_OUT +: W_OUT].
- out_sat  out  LANES  per-lane saturation flag for the current result.
- busy  out  1  a group is open (beat count is non-zero).

Behaviour:
- Reset (async, rst_n=0): all of the following clear immediately.
  - Beat count = 0, running sums = 0.
  - out_valid = 0, out_data = 0, out_sat = 0, busy = 0.
- A beat is accepted when in_valid && in_ready && !clear.
- Group length:
  - On a beat accepted with count==0, latch beats_lat = cfg_beats.
  - cfg_beats = 0 is treated as 1; values above MAX_BEATS clamp to MAX_BEATS.
  - cfg_beats changes mid-group are ignored.
- Last beat:
  - A beat is the last beat when count==beats_lat-1.
  - For the first beat of a group, use the clamped cfg_beats in that comparison.
  - beats=1 means every accepted beat is a complete group.
- Internal accumulator width: W_ACC = W_IN + $clog2(MAX_BEATS) per lane. It cannot overflow.
- Input extension: sign-extend when SIGNED=1, zero-extend when SIGNED=0.
- Non-last beat: sum += lane value; count += 1.
- Last beat:
  - Output register ← sum + lane value, then width-converted.
  - Running sum ← 0; count ← 0.
  - out_valid = 1 on the next cycle, so latency is 1 cycle from the last beat.
- Width conversion when W_OUT >= W_ACC: extend according to SIGNED; out_sat = 0.
- Width conversion when W_OUT < W_ACC:
  - SIGNED=1: clamp to [-2^(W_OUT-1), 2^(W_OUT-1)-1].
  - SIGNED=0: clamp to 2^W_OUT-1.
  - Set out_sat[i] for each clamped lane.
- Output handshake:
  - out_valid stays high, with out_data and out_sat stable, until out_ready is sampled high.
  - out_data and out_sat then hold their last values.
- in_ready rule: in_ready = !clear && !(next beat is last && out_valid && !out_ready).
  - Non-last beats are always accepted, even while the output stalls.
  - in_ready may depend combinationally on out_ready.
- Simultaneous drain and fill: if out_valid && out_ready coincide with a last beat, the new result loads and out_valid stays 1, giving full throughput.
- clear:
  - Zeroes count and running sums; any beat presented in the same cycle is dropped.
  - A pending output (out_valid=1) is unaffected.
- busy = (count != 0).
- Reset asserted mid-group or with output pending: everything is discarded and out_valid drops immediately.

Test Plan:
1. Defaults, cfg_beats=2, lane values (5,-3,100,0) then (7,3,-200,1) → one cycle after the 2nd beat: out_valid=1, out_data=(12,0,-100,1), out_sat=0.
2. cfg_beats=16, all lanes -131072 for 16 beats, W_OUT=22 → every lane = -2097152, out_sat=0. Repeat with W_OUT=20 → every lane = -524288, out_sat=4'b1111. Repeat with SIGNED=0 and all lanes 0x3FFFF, W_OUT=20 → every lane = 1048575, sat=1.
3. cfg_beats=1, in_valid held high, out_ready=1 → out_valid high every cycle from cycle 2, data equals the previous cycle's input, in_ready never drops.
4. cfg_beats=4, out_ready=0 with a result pending → beats 1-3 of the next group are accepted, and in_ready=0 on beat 4 until out_ready=1. The first result stays stable; the second result appears the cycle after the stalled beat is accepted.
5. cfg_beats=3, clear asserted after 2 beats with in_valid=1 → that beat is dropped and busy=0. The next 3 beats produce a result equal to only those 3 beats. cfg_beats changed to 8 mid-group → no effect until the next group.
6. rst_n pulsed low mid-group while out_valid=1 → out_valid, out_data and busy are 0 immediately. The first post-reset group sums from zero; cfg_beats=0 behaves as 1.
